// File: rtl/mlcd_pkg.sv
// Shared constants and types for the MLCD 8080-style write controller.
package mlcd_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CMD    = 2'd1;
  localparam logic [1:0] ADDR_TIMING = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 8;

  localparam int DW_MAX = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  typedef struct packed {
    logic              rs;
    logic [DW_MAX-1:0] data;
  } entry_t;

  // A programmed phase length of 0 behaves as 1 cycle
  function automatic logic [7:0] min1(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

endpackage

// File: rtl/mlcd_bus_if.sv
// Avalon-MM slave bundle for the MLCD controller register port.
interface mlcd_bus_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, read_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, read_n, writedata,
    output readdata
  );

endinterface

// File: rtl/mlcd_cmd_fifo.sv
// Synchronous command/pixel FIFO; full blocks push even with a same-cycle pop.
module mlcd_cmd_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mlcd_bus_ctrl.sv
// Avalon-MM slave sequencing queued 8080-style write cycles to the MLCD panel.
module mlcd_bus_ctrl
  import mlcd_pkg::*;
#(
  parameter int         DATA_W     = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] SETUP_RST  = 8'd2,
  parameter logic [7:0] PULSE_RST  = 8'd2,
  parameter logic [7:0] HOLD_RST   = 8'd1
) (
  input  logic              clk,
  input  logic              reset_n,
  mlcd_bus_if.slave         avs,
  output logic              lcd_cs_n,
  output logic              lcd_rs,
  output logic              lcd_wr_n,
  output logic              lcd_rd_n,
  output logic [DATA_W-1:0] lcd_data,
  output logic              busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic              w_wr;
  logic              w_push;
  logic              w_pop;
  logic              w_load;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [DATA_W:0]   w_fifo_q;
  entry_t            w_head;
  logic              w_unused;

  logic [23:0]       r_timing;
  logic              r_ovf;
  state_t            r_state,  w_state;
  logic [7:0]        r_cnt,    w_cnt;
  logic [7:0]        r_pulse,  w_pulse;
  logic [7:0]        r_hold,   w_hold;
  logic              r_cs_n,   w_cs_n;
  logic              r_wr_n,   w_wr_n;
  logic              r_rs,     w_rs;
  logic [DATA_W-1:0] r_data,   w_data;

  assign w_wr   = avs.chipselect & ~avs.write_n;
  assign w_push = w_wr & ((avs.address == ADDR_DATA) |
                          (avs.address == ADDR_CMD));
  assign w_head = entry_t'({w_fifo_q[DATA_W],
                            DW_MAX'(w_fifo_q[DATA_W-1:0])});
  assign w_unused = ^{avs.read_n, avs.writedata[31:24]};

  mlcd_cmd_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_wdata ({avs.address == ADDR_DATA,
               avs.writedata[DATA_W-1:0]}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_q),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timing <= {HOLD_RST, PULSE_RST, SETUP_RST};
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr && avs.address == ADDR_TIMING)
        r_timing <= avs.writedata[23:0];
      if (w_push && w_full)
        r_ovf <= 1'b1;
      else if (w_wr && avs.address == ADDR_STATUS &&
               avs.writedata[ST_OVF])
        r_ovf <= 1'b0;
    end
  end

  always_comb begin
    avs.readdata = '0;
    unique case (avs.address)
      ADDR_TIMING: avs.readdata = {8'd0, r_timing};
      ADDR_STATUS: begin
        avs.readdata[ST_BUSY]  = busy;
        avs.readdata[ST_FULL]  = w_full;
        avs.readdata[ST_EMPTY] = w_empty;
        avs.readdata[ST_OVF]   = r_ovf;
        avs.readdata[ST_CNT+:8] = 8'(w_count);
      end
      ADDR_DATA, ADDR_CMD: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pulse <= '0;
      r_hold  <= '0;
      r_cs_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_rs    <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_pulse <= w_pulse;
      r_hold  <= w_hold;
      r_cs_n  <= w_cs_n;
      r_wr_n  <= w_wr_n;
      r_rs    <= w_rs;
      r_data  <= w_data;
    end
  end

  // r_cnt holds the cycles remaining in the current phase minus one
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_pulse = r_pulse;
    w_hold  = r_hold;
    w_cs_n  = r_cs_n;
    w_wr_n  = r_wr_n;
    w_rs    = r_rs;
    w_data  = r_data;
    w_load  = 1'b0;
    w_pop   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cs_n = 1'b1;
        w_load = ~w_empty;
      end
      S_SETUP: begin
        if (r_cnt == 8'd0) begin
          w_state = S_STROBE;
          w_wr_n  = 1'b0;
          w_cnt   = r_pulse - 8'd1;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      S_STROBE: begin
        if (r_cnt == 8'd0) begin
          w_state = S_HOLD;
          w_wr_n  = 1'b1;
          w_cnt   = r_hold - 8'd1;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      S_HOLD: begin
        if (r_cnt != 8'd0) begin
          w_cnt = r_cnt - 8'd1;
        end else if (!w_empty) begin
          w_load = 1'b1;
        end else begin
          w_state = S_IDLE;
          w_cs_n  = 1'b1;
        end
      end
    endcase
    if (w_load) begin
      w_pop   = 1'b1;
      w_state = S_SETUP;
      w_cs_n  = 1'b0;
      w_wr_n  = 1'b1;
      w_rs    = w_head.rs;
      w_data  = w_head.data[DATA_W-1:0];
      w_cnt   = min1(r_timing[7:0]) - 8'd1;
      w_pulse = min1(r_timing[15:8]);
      w_hold  = min1(r_timing[23:16]);
    end
  end

  assign lcd_cs_n = r_cs_n;
  assign lcd_wr_n = r_wr_n;
  assign lcd_rs   = r_rs;
  assign lcd_data = r_data;
  assign lcd_rd_n = 1'b1;
  assign busy     = (r_state != S_IDLE) | ~w_empty;

endmodule

// File: tb/tb_mlcd_bus_ctrl.sv
// Directed bench for mlcd_bus_ctrl: per-cycle vector tables plus corner sequences.
module tb_mlcd_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, busy;
  logic [15:0] lcd_data;

  int checks = 0;
  int failures = 0;
  int n_strobes = 0;

  mlcd_bus_if bus ();

  mlcd_bus_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .avs      (bus),
    .lcd_cs_n (lcd_cs_n),
    .lcd_rs   (lcd_rs),
    .lcd_wr_n (lcd_wr_n),
    .lcd_rd_n (lcd_rd_n),
    .lcd_data (lcd_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge lcd_wr_n) n_strobes++;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        cs_n, wr_n, rs;
    logic [15:0] data;
    logic        busy;
  } vec_t;

  vec_t vq[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(logic [1:0] a, logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
  endtask

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.read_n     = 1'b1;
  endtask

  task automatic wr1(logic [1:0] a, logic [31:0] d);
    bus_wr(a, d);
    tick();
    bus_idle();
  endtask

  task automatic rd(logic [1:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    #1;
    d = bus.readdata;
    bus_idle();
  endtask

  task automatic add(logic cs, logic wr, logic rs, logic [15:0] d, logic b);
    vec_t v;
    v.we = 1'b0; v.addr = 2'd0; v.wdata = '0;
    v.cs_n = cs; v.wr_n = wr; v.rs = rs; v.data = d; v.busy = b;
    vq.push_back(v);
  endtask

  task automatic xfer(logic rs, logic [15:0] d, int s, int p, int h);
    for (int i = 0; i < s; i++) add(1'b0, 1'b1, rs, d, 1'b1);
    for (int i = 0; i < p; i++) add(1'b0, 1'b0, rs, d, 1'b1);
    for (int i = 0; i < h; i++) add(1'b0, 1'b1, rs, d, 1'b1);
  endtask

  task automatic stim(int idx, logic [1:0] a, logic [31:0] d);
    vq[idx].we = 1'b1;
    vq[idx].addr = a;
    vq[idx].wdata = d;
  endtask

  task automatic run(string nm);
    foreach (vq[i]) begin
      if (vq[i].we) bus_wr(vq[i].addr, vq[i].wdata);
      tick();
      bus_idle();
      chk($sformatf("%s[%0d]", nm, i),
          32'({lcd_cs_n, lcd_wr_n, lcd_rs, lcd_data, busy}),
          32'({vq[i].cs_n, vq[i].wr_n, vq[i].rs, vq[i].data, vq[i].busy}));
    end
    vq.delete();
  endtask

  logic [31:0] r;
  int          snap, cyc, cur;
  int          runs[$];
  bit          wrote, cs_glitch;

  initial begin
    bus.address = 2'd0;
    bus.writedata = '0;
    bus_idle();
    repeat (3) tick();
    chk("rst_pins", 32'({lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs, lcd_data, busy}),
        32'({1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0}));
    rd(2'd3, r); chk("rst_status", r, 32'h4);
    rd(2'd2, r); chk("rst_timing", r, 32'h010202);
    reset_n = 1'b1;
    tick();

    // single command, default timing 2/2/1
    add(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    xfer(1'b0, 16'h002C, 2, 2, 1);
    add(1'b1, 1'b1, 1'b0, 16'h002C, 1'b0);
    stim(0, 2'd1, 32'h2C);
    run("single");

    // burst keeps cs_n low across three transfers
    add(1'b1, 1'b1, 1'b0, 16'h002C, 1'b1);
    xfer(1'b0, 16'h002C, 2, 2, 1);
    xfer(1'b1, 16'hF800, 2, 2, 1);
    xfer(1'b1, 16'h07E0, 2, 2, 1);
    add(1'b1, 1'b1, 1'b1, 16'h07E0, 1'b0);
    stim(0, 2'd1, 32'h2C);
    stim(1, 2'd0, 32'hF800);
    stim(2, 2'd0, 32'h07E0);
    run("burst");

    // hold 0 behaves as 1
    add(1'b1, 1'b1, 1'b1, 16'h07E0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 16'h07E0, 1'b1);
    xfer(1'b1, 16'h1234, 2, 3, 1);
    add(1'b1, 1'b1, 1'b1, 16'h1234, 1'b0);
    stim(0, 2'd2, 32'h000302);
    stim(1, 2'd0, 32'h1234);
    run("timing");
    rd(2'd2, r); chk("timing_rb", r, 32'h00000302);
    rd(2'd0, r); chk("data_rd0", r, 32'h0);
    rd(2'd1, r); chk("cmd_rd0", r, 32'h0);

    // overflow: long strobe stalls the queue
    wr1(2'd2, 32'h01FF02);
    snap = n_strobes;
    for (int i = 0; i < 10; i++) wr1(2'd0, 32'h0100 + i);
    rd(2'd3, r); chk("ovf_status", r, 32'h0000080B);
    wr1(2'd3, 32'h8);
    rd(2'd3, r); chk("ovf_clear", r, 32'h00000803);
    wr1(2'd2, 32'h010202);
    cyc = 0;
    while (busy && cyc < 2000) begin tick(); cyc++; end
    chk("ovf_drain", 32'(busy), 32'h0);
    chk("ovf_xfers", 32'(n_strobes - snap), 32'd9);
    chk("ovf_last", 32'(lcd_data), 32'h0108);

    // TIMING change during first word's strobe
    wr1(2'd0, 32'h1111);
    wr1(2'd0, 32'h2222);
    wrote = 1'b0; cur = 0; cs_glitch = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!lcd_wr_n && !wrote) begin
        bus_wr(2'd2, 32'h010402);
        wrote = 1'b1;
      end
      tick();
      bus_idle();
      if (!lcd_wr_n) cur++;
      else if (cur > 0) begin runs.push_back(cur); cur = 0; end
      if (runs.size() == 1 && lcd_cs_n) cs_glitch = 1'b1;
    end
    chk("mid_runs", 32'(runs.size()), 32'd2);
    chk("mid_pulse0", (runs.size() > 0) ? 32'(runs[0]) : 32'hFFFF, 32'd2);
    chk("mid_pulse1", (runs.size() > 1) ? 32'(runs[1]) : 32'hFFFF, 32'd4);
    chk("mid_cs_low", 32'(cs_glitch), 32'h0);
    chk("mid_data", 32'(lcd_data), 32'h2222);

    // asynchronous reset in the middle of a strobe
    wr1(2'd2, 32'h010203);
    wr1(2'd0, 32'hAAAA);
    wr1(2'd0, 32'h5555);
    cyc = 0;
    while (lcd_wr_n && cyc < 50) begin tick(); cyc++; end
    chk("rst_reach_strobe", 32'(lcd_wr_n), 32'h0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_pins", 32'({lcd_cs_n, lcd_wr_n, lcd_rs, lcd_data, busy}),
        32'({1'b1, 1'b1, 1'b0, 16'h0, 1'b0}));
    rd(2'd3, r); chk("rst_mid_status", r, 32'h4);
    rd(2'd2, r); chk("rst_mid_timing", r, 32'h010202);
    snap = n_strobes;
    tick(); tick();
    reset_n = 1'b1;
    cs_glitch = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (!lcd_cs_n || busy) cs_glitch = 1'b1;
    end
    chk("rst_no_xfer", 32'(cs_glitch), 32'h0);
    chk("rst_no_strobe", 32'(n_strobes - snap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mlcd_bus_ctrl.md
Name: mlcd_bus_ctrl

Overview:
- Avalon-MM slave that sequences 8080-style write cycles to the main parallel LCD (MLCD) panel.
- Drives CS_n, RS, WR_n and the data bus; software no longer bit-bangs the PIO chip-select and strobe lines.
- Commands and pixel data are queued in a small FIFO and emitted with programmable setup, strobe and hold timing.
- Sits in system_qsys beside the PIO peripherals, clocked from the Nios II system clock.

Parameters:
- DATA_W, 16, LCD data bus width (8 or 16).
- FIFO_DEPTH, 8, command FIFO entries; power of 2, minimum 2.
- SETUP_RST, 2, reset value of setup cycles (RS/data valid to WR_n fall).
- PULSE_RST, 2, reset value of WR_n low cycles.
- HOLD_RST, 1, reset value of cycles after WR_n rise before next setup or CS_n release.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset (see Behaviour).
- address  in  2  register select.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  Avalon write strobe, active-low.
- read_n  in  1  Avalon read strobe, active-low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, read latency 0, combinational from address.
- lcd_cs_n  out  1  LCD chip select, active-low.
- lcd_rs  out  1  register select: 0 = command, 1 = data.
- lcd_wr_n  out  1  write strobe, active-low.
- lcd_rd_n  out  1  read strobe; constant 1 (write-only controller).
- lcd_data  out  DATA_W  LCD data bus.
- busy  out  1  high when FSM not IDLE or FIFO non-empty.

Behaviour:
- Reset: reset reset_n, asynchronous, active-low; clock clk.
  - Reset values: lcd_cs_n=1, lcd_wr_n=1, lcd_rd_n=1, lcd_rs=0, lcd_data=0, busy=0.
  - FIFO empty, overflow=0, TIMING = {HOLD_RST, PULSE_RST, SETUP_RST}.
  - Reset mid-transfer aborts the transfer immediately; all outputs return to reset values.
- Register map (write = chipselect & ~write_n):
  - 0 DATA: write pushes {rs=1, writedata[DATA_W-1:0]}.
  - 1 CMD: write pushes {rs=0, writedata[DATA_W-1:0]}.
  - 2 TIMING: R/W; [7:0] setup, [15:8] pulse, [23:16] hold; other bits read 0.
  - 3 STATUS: read returns [0] busy, [1] full, [2] empty, [3] overflow (sticky), [15:8] FIFO count; writing bit3=1 clears overflow.
  - Reads of addresses 0 and 1 return 0.
- FIFO:
  - Push while full drops the word and sets overflow. Full blocks a push even if a pop occurs the same cycle.
  - A pop is only issued when not empty. A push into an empty FIFO is visible to the FSM the next cycle.
- FSM states: IDLE, SETUP, STROBE, HOLD. All LCD outputs are registered.
  - IDLE: if FIFO non-empty, pop the head, latch rs/data and the TIMING fields (a field value of 0 is treated as 1), set cs_n=0, enter SETUP. Otherwise cs_n=1.
  - SETUP: wr_n=1 for `setup` cycles, then enter STROBE with wr_n=0.
  - STROBE: wr_n=0 for `pulse` cycles, then enter HOLD with wr_n=1.
  - HOLD: data/rs held for `hold` cycles. At the end:
    - FIFO non-empty: pop and re-enter SETUP with cs_n held low (burst).
    - FIFO empty: cs_n=1, enter IDLE.
- Latency:
  - Avalon write in cycle T; cs_n falls and data/rs are valid in cycle T+2.
  - Each transfer occupies setup+pulse+hold cycles.
- TIMING writes during a transfer affect only subsequently popped entries.
- lcd_data and lcd_rs change only when an entry is loaded; they hold their value in IDLE.

Decomposition:
- Package mlcd_pkg:
  - Register address constants ADDR_DATA/CMD/TIMING/STATUS.
  - FSM state enum.
  - STATUS bit positions.
  - FIFO entry typedef {rs, data}.
- One sub-module: mlcd_cmd_fifo.
  - Synchronous FIFO, width DATA_W+1, depth FIFO_DEPTH.
  - Outputs full/empty/count.
  - Same clk and reset_n.

Test Plan:
- Single command: reset, write CMD 0x2C with default timing.
  - cs_n low at T+2, rs=0, data=0x002C.
  - wr_n low for exactly 2 cycles after 2 setup cycles.
  - cs_n high after 1 hold cycle; busy returns to 0.
- Burst: write CMD 0x2C, then DATA 0xF800, DATA 0x07E0 back-to-back.
  - cs_n stays low across all three transfers with rs sequence 0,1,1.
  - Three wr_n pulses, each transfer 5 cycles.
- Timing: write TIMING=0x000302 (hold 0 → 1), then DATA 0x1234.
  - Setup 2, pulse 3, hold 1 cycles.
  - Readback of TIMING = 0x00000302.
- Overflow: stall with TIMING pulse=0xFF, push 10 words.
  - STATUS shows full=1, overflow=1; only 9 transfers emerge (1 in flight + 8 queued).
  - Writing STATUS bit3 clears overflow.
- Reset mid-STROBE: assert reset_n=0 while wr_n=0.
  - Same cycle, cs_n=1, wr_n=1, data=0; FIFO empty.
  - After release, no transfer is emitted.
- TIMING change mid-transfer: queue two words, write pulse=4 during the first word's STROBE.
  - First word keeps pulse 2; second word uses pulse 4.
